// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 types, constants and GF(2^8) helpers
package aes_pkg;

  localparam int AES_NR = 10;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] rkey_t;

  // Padded to 16 entries so a 4-bit round counter can index it without range checks
  localparam logic [7:0] RCON [0:15] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  typedef logic [1:0] ke_state_t;
  localparam ke_state_t KE_IDLE   = 2'd0;
  localparam ke_state_t KE_EXPAND = 2'd1;
  localparam ke_state_t KE_DONE   = 2'd2;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES S-box (GF(2^8) inverse plus affine map)
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  localparam logic [7:0] INV_EXP = 8'hfe;

  logic [7:0] w_inv;
  logic [7:0] w_base;

  // x^254 is the multiplicative inverse and conveniently maps 0 to 0
  always_comb begin
    w_inv  = 8'h01;
    w_base = i_byte;
    for (int i = 0; i < 8; i++) begin
      if (INV_EXP[i]) w_inv = gf_mul(w_inv, w_base);
      w_base = gf_mul(w_base, w_base);
    end
  end

  assign o_byte = w_inv
                ^ {w_inv[6:0], w_inv[7]}
                ^ {w_inv[5:0], w_inv[7:6]}
                ^ {w_inv[4:0], w_inv[7:5]}
                ^ {w_inv[3:0], w_inv[7:4]}
                ^ 8'h63;

endmodule

// File: rtl/key_expand.sv
// rtl/key_expand.sv - AES-128 key expansion, one round key per clock
// Optional zeroize port under KEY_EXPAND_ZEROIZE_EN.
module key_expand
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_NR,
  parameter int KEY_W      = 128
)
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [KEY_W-1:0]      key_in,
  output logic                  busy,
  output logic                  key_done,
  output logic [NUM_ROUNDS:0]   key_valid,
  input  logic [3:0]            rd_idx,
`ifdef KEY_EXPAND_ZEROIZE_EN
  input  logic                  key_clear,
`endif
  output logic [KEY_W-1:0]      rd_key
);

  ke_state_t          r_state;
  logic [3:0]         r_round;
  logic [NUM_ROUNDS:0] r_key_valid;
  rkey_t              r_rk [0:NUM_ROUNDS];
  rkey_t              r_rd_key;

  logic               w_clear;
  logic [3:0]         w_prev_idx;
  rkey_t              w_prev;
  rkey_t              w_next;
  word_t              w_w0, w_w1, w_w2, w_w3;
  word_t              w_rot;
  word_t              w_sub;
  word_t              w_n0, w_n1, w_n2, w_n3;

`ifdef KEY_EXPAND_ZEROIZE_EN
  assign w_clear = rst | key_clear;
`else
  assign w_clear = rst;
`endif

  assign w_prev_idx = (r_round == 4'd0) ? 4'd0 : r_round - 4'd1;
  assign w_prev     = r_rk[w_prev_idx];
  assign {w_w0, w_w1, w_w2, w_w3} = w_prev;
  assign w_rot      = {w_w3[23:0], w_w3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (
      .i_byte (w_rot[8*g +: 8]),
      .o_byte (w_sub[8*g +: 8])
    );
  end

  assign w_n0   = w_w0 ^ w_sub ^ {RCON[r_round], 24'h000000};
  assign w_n1   = w_w1 ^ w_n0;
  assign w_n2   = w_w2 ^ w_n1;
  assign w_n3   = w_w3 ^ w_n2;
  assign w_next = {w_n0, w_n1, w_n2, w_n3};

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_state     <= KE_IDLE;
      r_round     <= 4'd0;
      r_key_valid <= '0;
      r_rd_key    <= '0;
      for (int i = 0; i <= NUM_ROUNDS; i++) r_rk[i] <= '0;
    end else begin
      r_rd_key <= (rd_idx <= 4'(NUM_ROUNDS)) ? r_rk[rd_idx] : '0;
      case (r_state)
        KE_IDLE, KE_DONE: begin
          if (start) begin
            r_rk[0]     <= key_in;
            r_key_valid <= {{NUM_ROUNDS{1'b0}}, 1'b1};
            r_round     <= 4'd1;
            r_state     <= KE_EXPAND;
          end
        end
        KE_EXPAND: begin
          // start is deliberately ignored here; an expansion always runs to completion
          r_rk[r_round]        <= w_next;
          r_key_valid[r_round] <= 1'b1;
          r_round              <= r_round + 4'd1;
          if (r_round == 4'(NUM_ROUNDS)) r_state <= KE_DONE;
        end
        default: r_state <= KE_IDLE;
      endcase
    end
  end

  assign busy      = (r_state == KE_EXPAND);
  assign key_done  = (r_state == KE_DONE);
  assign key_valid = r_key_valid;
  assign rd_key    = r_rd_key;

endmodule

// File: tb/tb_key_expand.sv
// tb/tb_key_expand.sv - scoreboard bench for key_expand
module tb_key_expand;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         key_done;
  logic [10:0]  key_valid;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;
`ifdef KEY_EXPAND_ZEROIZE_EN
  logic         key_clear;
`endif

  always #5 clk = ~clk;

  key_expand dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key_in    (key_in),
    .busy      (busy),
    .key_done  (key_done),
    .key_valid (key_valid),
    .rd_idx    (rd_idx),
`ifdef KEY_EXPAND_ZEROIZE_EN
    .key_clear (key_clear),
`endif
    .rd_key    (rd_key)
  );

  int           n_vec = 0;
  int           n_err = 0;
  logic [127:0] sb_q [$];
  string        sbt_q [$];
  logic [7:0]   sbx [0:255];
  logic [127:0] exp_rk [0:10];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK1 = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box from exp/log tables over generator 3, bitwise affine map
  task automatic build_sbox();
    logic [7:0] ex [0:255];
    int         lg [0:255];
    logic [7:0] x;
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] cst;
    cst = 8'h63;
    x = 8'h01;
    for (int i = 0; i < 255; i++) begin
      ex[i] = x;
      lg[x] = i;
      x = x ^ xt(x);
    end
    for (int a = 0; a < 256; a++) begin
      inv = (a == 0) ? 8'h00 : ex[(255 - lg[a]) % 255];
      for (int b = 0; b < 8; b++)
        s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ cst[b];
      sbx[a] = s;
    end
  endtask

  function automatic logic [127:0] nk(input logic [127:0] p, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    {w0, w1, w2, w3} = p;
    t  = {sbx[w3[23:16]], sbx[w3[15:8]], sbx[w3[7:0]], sbx[w3[31:24]]};
    n0 = w0 ^ t ^ {rc, 24'h0};
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  task automatic model_expand(input logic [127:0] key);
    logic [7:0] rc;
    rc = 8'h01;
    exp_rk[0] = key;
    for (int r = 1; r <= 10; r++) begin
      exp_rk[r] = nk(exp_rk[r-1], rc);
      rc = xt(rc);
    end
  endtask

  task automatic sb_push(input string tag, input logic [127:0] v);
    sb_q.push_back(v);
    sbt_q.push_back(tag);
  endtask

  task automatic sb_pop_check();
    logic [127:0] v;
    string        t;
    v = sb_q.pop_front();
    t = sbt_q.pop_front();
    chk(t, rd_key, v);
  endtask

  task automatic read_idx(input logic [3:0] idx, input logic [127:0] want, input string tag);
    rd_idx = idx;
    sb_push(tag, want);
    @(posedge clk); #1;
    sb_pop_check();
  endtask

  task automatic sweep(input string pfx);
    for (int i = 0; i < 16; i++)
      read_idx(4'(i), (i <= 10) ? exp_rk[i] : 128'h0, $sformatf("%s_idx%0d", pfx, i));
  endtask

  // Launch at edge T, then check every edge up to T+11; poke adds starts at T+4 and T+10
  task automatic run_expand(input logic [127:0] key, input bit poke, input string pfx);
    int mask;
    model_expand(key);
    key_in = key;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    key_in = {$urandom, $urandom, $urandom, $urandom};
    chk({pfx, "_busy_T"}, {127'b0, busy}, 128'd1);
    chk({pfx, "_done_T"}, {127'b0, key_done}, 128'd0);
    chk({pfx, "_kv_T"}, {117'b0, key_valid}, 128'h1);
    for (int n = 1; n <= 10; n++) begin
      if (poke && (n == 4 || n == 10)) begin
        start  = 1'b1;
        key_in = {$urandom, $urandom, $urandom, $urandom};
      end
      @(posedge clk); #1;
      start = 1'b0;
      mask  = (1 << (n + 1)) - 1;
      chk($sformatf("%s_kv_T%0d", pfx, n), {117'b0, key_valid}, 128'(mask));
      chk($sformatf("%s_done_T%0d", pfx, n), {127'b0, key_done}, (n == 10) ? 128'd1 : 128'd0);
      chk($sformatf("%s_busy_T%0d", pfx, n), {127'b0, busy}, (n == 10) ? 128'd0 : 128'd1);
      if (n > 1) sb_pop_check();
      rd_idx = 4'(n);
      sb_push($sformatf("%s_live_rk%0d", pfx, n), exp_rk[n]);
    end
    @(posedge clk); #1;
    sb_pop_check();
    chk({pfx, "_done_hold"}, {127'b0, key_done}, 128'd1);
    chk({pfx, "_busy_hold"}, {127'b0, busy}, 128'd0);
  endtask

  initial begin
    build_sbox();
    rst    = 1'b1;
    start  = 1'b0;
    key_in = '0;
    rd_idx = '0;
`ifdef KEY_EXPAND_ZEROIZE_EN
    key_clear = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_busy", {127'b0, busy}, 128'd0);
    chk("rst_done", {127'b0, key_done}, 128'd0);
    chk("rst_kv", {117'b0, key_valid}, 128'd0);
    chk("rst_rdkey", rd_key, 128'd0);

    run_expand(FIPS_KEY, 1'b0, "fips");
    read_idx(4'd1, FIPS_RK1, "fips_rk1_const");
    read_idx(4'd10, FIPS_RK10, "fips_rk10_const");
    sweep("fips");

    run_expand(128'h0, 1'b1, "zero");
    read_idx(4'd1, ZERO_RK1, "zero_rk1_const");
    read_idx(4'd10, ZERO_RK10, "zero_rk10_const");

    run_expand({$urandom, $urandom, $urandom, $urandom}, 1'b0, "rnd1");
    sweep("rnd1");

    key_in = FIPS_KEY;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy", {127'b0, busy}, 128'd0);
    chk("midrst_done", {127'b0, key_done}, 128'd0);
    chk("midrst_kv", {117'b0, key_valid}, 128'd0);
    chk("midrst_rdkey", rd_key, 128'd0);
    read_idx(4'd3, 128'h0, "midrst_rk3");
    read_idx(4'd0, 128'h0, "midrst_rk0");

    run_expand({$urandom, $urandom, $urandom, $urandom}, 1'b0, "rnd2");
    sweep("rnd2");

`ifdef KEY_EXPAND_ZEROIZE_EN
    key_clear = 1'b1;
    @(posedge clk); #1;
    key_clear = 1'b0;
    chk("zz_busy", {127'b0, busy}, 128'd0);
    chk("zz_done", {127'b0, key_done}, 128'd0);
    chk("zz_kv", {117'b0, key_valid}, 128'd0);
    chk("zz_rdkey", rd_key, 128'd0);
    for (int i = 0; i <= 10; i++) exp_rk[i] = '0;
    sweep("zz");
    key_in    = {$urandom, $urandom, $urandom, $urandom};
    start     = 1'b1;
    key_clear = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    key_clear = 1'b0;
    chk("zzst_busy", {127'b0, busy}, 128'd0);
    chk("zzst_kv", {117'b0, key_valid}, 128'd0);
    @(posedge clk); #1;
    chk("zzst_busy2", {127'b0, busy}, 128'd0);
    chk("zzst_done2", {127'b0, key_done}, 128'd0);
    read_idx(4'd0, 128'h0, "zzst_rk0");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
